// File: rtl/linebuf_pkg.sv
// linebuf_pkg: bank-address helpers shared by the ping-pong line buffer.
// The physical RAM address is {bank, idx}; BANK_W is the width of the bank
// field that sits above the per-bank index.
package linebuf_pkg;
  localparam int   BANK_W = 1;
  localparam logic BANK_0 = 1'b0;
  localparam logic BANK_1 = 1'b1;
endpackage

// File: rtl/linebuf_pp_if.sv
// linebuf_pp_if: render-side, display-side and swap signals of the ping-pong
// line buffer, bundled into one interface.
//   master : renderer / video pipeline (drives requests, receives data)
//   slave  : linebuf_pp
// Signals:
//   swap, linesel                          bank exchange / current render bank
//   r_idx, r_wrdata, r_wren, r_rddata      render port
//   d_load, d_load_idx, d_rden, d_clr_en   display scan control
//   d_rddata, d_valid, d_ptr               display scan results
interface linebuf_pp_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 9,
  parameter int OUT_W  = 6
);
  logic              swap;
  logic              linesel;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wrdata;
  logic              r_wren;
  logic [DATA_W-1:0] r_rddata;
  logic              d_load;
  logic [IDX_W-1:0]  d_load_idx;
  logic              d_rden;
  logic              d_clr_en;
  logic [OUT_W-1:0]  d_rddata;
  logic              d_valid;
  logic [IDX_W-1:0]  d_ptr;

  modport master (
    output swap, r_idx, r_wrdata, r_wren, d_load, d_load_idx, d_rden, d_clr_en,
    input  linesel, r_rddata, d_rddata, d_valid, d_ptr
  );

  modport slave (
    input  swap, r_idx, r_wrdata, r_wren, d_load, d_load_idx, d_rden, d_clr_en,
    output linesel, r_rddata, d_rddata, d_valid, d_ptr
  );
endinterface

// File: rtl/dpram_tdp.sv
// dpram_tdp: generic inferred true-dual-port RAM, one clock.
// Each port has enable, write enable, address, write data and a registered
// read output (1-cycle latency). MODE_A / MODE_B select "WRITE_FIRST"
// (output shows the data being written) or "READ_FIRST" (output shows the
// old contents). srst clears only the output registers; memory writes are
// never gated by it.
module dpram_tdp #(
  parameter int    DATA_W = 8,
  parameter int    ADDR_W = 10,
  parameter string MODE_A = "WRITE_FIRST",
  parameter string MODE_B = "READ_FIRST"
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);
  localparam bit A_WF = (MODE_A == "WRITE_FIRST");
  localparam bit B_WF = (MODE_B == "WRITE_FIRST");

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_a_reg;
  logic [DATA_W-1:0] dout_b_reg;

  always_ff @(posedge clk) begin
    if (en_a && we_a) mem[addr_a] <= din_a;
    if (en_b && we_b) mem[addr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    if (srst)
      dout_a_reg <= '0;
    else if (en_a)
      dout_a_reg <= (A_WF && we_a) ? din_a : mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (srst)
      dout_b_reg <= '0;
    else if (en_b)
      dout_b_reg <= (B_WF && we_b) ? din_b : mem[addr_b];
  end

  assign dout_a = dout_a_reg;
  assign dout_b = dout_b_reg;
endmodule

// File: rtl/linebuf_pp.sv
// linebuf_pp: ping-pong video line buffer.
// The renderer composes the next line in bank linesel through port A
// (write-first, read every cycle) while the display side scans bank !linesel
// through port B (read-first, optional read-and-clear) using an
// auto-incrementing, wrapping scan pointer.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         linebuf_pp_if.slave (render, display and swap signals)
module linebuf_pp
  import linebuf_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                IDX_W     = 9,
  parameter int                LINE_LEN  = 512,
  parameter int                OUT_W     = 6,
  parameter int                PIX_W     = 4,
  parameter int                TRANSP_EN = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  linebuf_pp_if.slave  bus
);
  localparam int               AW     = BANK_W + IDX_W;
  localparam logic [IDX_W:0]   LEN_C  = (IDX_W+1)'(LINE_LEN);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(LINE_LEN - 1);

  logic             linesel_reg;
  logic [IDX_W-1:0] d_ptr_reg, d_ptr_next;
  logic             d_valid_reg;

  logic              r_in_range, r_opaque, r_we;
  logic              d_go, d_we;
  logic [DATA_W-1:0] ram_a_q, ram_b_q;

  // A write lands only inside the visible line and only for non-transparent
  // pixels, so sprites never punch holes into what is already composed.
  assign r_in_range = ({1'b0, bus.r_idx} < LEN_C);
  assign r_opaque   = !((TRANSP_EN != 0) && (bus.r_wrdata[PIX_W-1:0] == '0));
  assign r_we       = bus.r_wren && r_in_range && r_opaque;

  // A load cycle consumes the slot: no read and no clear happen then.
  assign d_go = bus.d_rden && !bus.d_load;
  assign d_we = d_go && bus.d_clr_en;

  always_comb begin
    d_ptr_next = d_ptr_reg;
    if (bus.d_load)
      d_ptr_next = ({1'b0, bus.d_load_idx} < LEN_C) ? bus.d_load_idx : '0;
    else if (d_go)
      d_ptr_next = (d_ptr_reg == LAST_C) ? '0 : d_ptr_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      linesel_reg <= BANK_0;
      d_ptr_reg   <= '0;
      d_valid_reg <= 1'b0;
    end else begin
      if (bus.swap) linesel_reg <= ~linesel_reg;
      d_ptr_reg   <= d_ptr_next;
      d_valid_reg <= d_go;
    end
  end

  // Bank select uses the pre-edge linesel, so a swap-cycle access still
  // targets the old banks; the two ports always sit in opposite banks.
  dpram_tdp #(
    .DATA_W (DATA_W),
    .ADDR_W (AW),
    .MODE_A ("WRITE_FIRST"),
    .MODE_B ("READ_FIRST")
  ) u_ram (
    .clk    (clk),
    .srst   (reset),
    .en_a   (1'b1),
    .we_a   (r_we),
    .addr_a ({linesel_reg, bus.r_idx}),
    .din_a  (bus.r_wrdata),
    .dout_a (ram_a_q),
    .en_b   (d_go),
    .we_b   (d_we),
    .addr_b ({~linesel_reg, d_ptr_reg}),
    .din_b  (CLEAR_VAL),
    .dout_b (ram_b_q)
  );

  // Display output carries only the low OUT_W bits of each entry.
  generate
    if (OUT_W < DATA_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^ram_b_q[DATA_W-1:OUT_W];
    end
  endgenerate

  assign bus.linesel  = linesel_reg;
  assign bus.r_rddata = ram_a_q;
  assign bus.d_rddata = ram_b_q[OUT_W-1:0];
  assign bus.d_valid  = d_valid_reg;
  assign bus.d_ptr    = d_ptr_reg;
endmodule
